// File: rtl/cordic_fsm_ctrl.sv
// cordic_fsm_ctrl: control sequencer for the iterative CORDIC sine/cosine datapath.
// Optional build macro: CORDIC_FSM_AUTO_RESTART_EN. When it is defined, READY goes
// straight to LOAD if ACK_FSM_CORDIC and beg_FSM_CORDIC are both high in the same cycle.
// Ports:
//   clk, reset (async, active-low)
//   beg_FSM_CORDIC / ACK_FSM_CORDIC / ready_CORDIC : start and result handshake
//   operation, shift_region_flag                   : output X/Y selection inputs
//   cont_var, *_tick_iter, *_tick_var               : counter status from the datapath
//   ready_add_subt / beg_add_subt / ack_add_subt    : shared adder handshake
//   sel_mux_*, mode, enab_*, load_*                 : datapath selects and enables
// Outputs are a combinational decode of the state. They are forced to 0 while reset is low.
module cordic_fsm_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       beg_FSM_CORDIC,
  input  logic       ACK_FSM_CORDIC,
  input  logic       operation,
  input  logic [1:0] shift_region_flag,
  input  logic [1:0] cont_var,
  input  logic       ready_add_subt,
  input  logic       max_tick_iter,
  input  logic       min_tick_iter,
  input  logic       max_tick_var,
  input  logic       min_tick_var,
  output logic       ready_CORDIC,
  output logic       beg_add_subt,
  output logic       ack_add_subt,
  output logic       sel_mux_1,
  output logic [1:0] sel_mux_2,
  output logic       sel_mux_3,
  output logic       mode,
  output logic       enab_cont_iter,
  output logic       load_cont_iter,
  output logic       enab_cont_var,
  output logic       load_cont_var,
  output logic       enab_RB1,
  output logic       enab_RB2,
  output logic       enab_d_ff_Xn,
  output logic       enab_d_ff_Yn,
  output logic       enab_d_ff_Zn,
  output logic       enab_dff5,
  output logic       enab_d_ff_out,
  output logic       enab_dff_shifted_x,
  output logic       enab_dff_shifted_y,
  output logic       enab_dff_LUT,
  output logic       enab_dff_sign
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_MUX   = 4'd2;
  localparam logic [3:0] S_SHIFT = 4'd3;
  localparam logic [3:0] S_ADD   = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_ITER  = 4'd6;
  localparam logic [3:0] S_OUT1  = 4'd7;
  localparam logic [3:0] S_OUT2  = 4'd8;
  localparam logic [3:0] S_READY = 4'd9;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       swap_xy;

  // The minimum-tick flag is not needed by this sequencer.
  logic unused_min_tick_var;
  assign unused_min_tick_var = min_tick_var;

  // Regions 01 and 10 exchange the roles of X and Y at the output.
  assign swap_xy = shift_region_flag[1] ^ shift_region_flag[0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode. All outputs stay 0 while reset is held low.
  always_comb begin
    state_nxt          = state;
    ready_CORDIC       = 1'b0;
    beg_add_subt       = 1'b0;
    ack_add_subt       = 1'b0;
    sel_mux_1          = 1'b0;
    sel_mux_2          = 2'b00;
    sel_mux_3          = 1'b0;
    mode               = 1'b0;
    enab_cont_iter     = 1'b0;
    load_cont_iter     = 1'b0;
    enab_cont_var      = 1'b0;
    load_cont_var      = 1'b0;
    enab_RB1           = 1'b0;
    enab_RB2           = 1'b0;
    enab_d_ff_Xn       = 1'b0;
    enab_d_ff_Yn       = 1'b0;
    enab_d_ff_Zn       = 1'b0;
    enab_dff5          = 1'b0;
    enab_d_ff_out      = 1'b0;
    enab_dff_shifted_x = 1'b0;
    enab_dff_shifted_y = 1'b0;
    enab_dff_LUT       = 1'b0;
    enab_dff_sign      = 1'b0;

    if (reset) begin
      case (state)
        S_IDLE: begin
          load_cont_iter = 1'b1;
          load_cont_var  = 1'b1;
          if (beg_FSM_CORDIC) state_nxt = S_LOAD;
        end
        S_LOAD: begin
          enab_RB1       = 1'b1;
          load_cont_iter = 1'b1;
          load_cont_var  = 1'b1;
          state_nxt      = S_MUX;
        end
        S_MUX: begin
          enab_RB2  = 1'b1;
          sel_mux_1 = ~min_tick_iter;
          state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          enab_dff_shifted_x = 1'b1;
          enab_dff_shifted_y = 1'b1;
          enab_dff_LUT       = 1'b1;
          enab_dff_sign      = 1'b1;
          sel_mux_1          = ~min_tick_iter;
          state_nxt          = S_ADD;
        end
        S_ADD: begin
          beg_add_subt = 1'b1;
          sel_mux_2    = cont_var;
          state_nxt    = S_WAIT;
        end
        S_WAIT: begin
          sel_mux_2 = cont_var;
          if (ready_add_subt) begin
            // Commit the current variable and acknowledge in the same cycle.
            ack_add_subt  = 1'b1;
            enab_cont_var = 1'b1;
            enab_d_ff_Xn  = (cont_var == 2'b00);
            enab_d_ff_Yn  = (cont_var == 2'b01);
            enab_d_ff_Zn  = (cont_var == 2'b10);
            state_nxt     = max_tick_var ? S_ITER : S_ADD;
          end
        end
        S_ITER: begin
          if (max_tick_iter) begin
            state_nxt = S_OUT1;
          end else begin
            enab_cont_iter = 1'b1;
            load_cont_var  = 1'b1;
            state_nxt      = S_MUX;
          end
        end
        S_OUT1: begin
          enab_dff5 = 1'b1;
          sel_mux_3 = operation ^ swap_xy;
          state_nxt = S_OUT2;
        end
        S_OUT2: begin
          enab_d_ff_out = 1'b1;
          sel_mux_3     = operation ^ swap_xy;
          state_nxt     = S_READY;
        end
        S_READY: begin
          ready_CORDIC = 1'b1;
          if (ACK_FSM_CORDIC) begin
`ifdef CORDIC_FSM_AUTO_RESTART_EN
            state_nxt = beg_FSM_CORDIC ? S_LOAD : S_IDLE;
`else
            state_nxt = S_IDLE;
`endif
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_fsm_ctrl.sv
// Directed testbench for cordic_fsm_ctrl. All 23 output bits are packed into one
// vector and compared against hand-built expected masks.
module tb_cordic_fsm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       beg_FSM_CORDIC, ACK_FSM_CORDIC, operation;
  logic [1:0] shift_region_flag, cont_var;
  logic       ready_add_subt, max_tick_iter, min_tick_iter, max_tick_var, min_tick_var;
  logic       ready_CORDIC, beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_3, mode;
  logic [1:0] sel_mux_2;
  logic       enab_cont_iter, load_cont_iter, enab_cont_var, load_cont_var;
  logic       enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn;
  logic       enab_dff5, enab_d_ff_out, enab_dff_shifted_x, enab_dff_shifted_y;
  logic       enab_dff_LUT, enab_dff_sign;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  cordic_fsm_ctrl dut (
    .clk(clk), .reset(reset),
    .beg_FSM_CORDIC(beg_FSM_CORDIC), .ACK_FSM_CORDIC(ACK_FSM_CORDIC),
    .operation(operation), .shift_region_flag(shift_region_flag),
    .cont_var(cont_var), .ready_add_subt(ready_add_subt),
    .max_tick_iter(max_tick_iter), .min_tick_iter(min_tick_iter),
    .max_tick_var(max_tick_var), .min_tick_var(min_tick_var),
    .ready_CORDIC(ready_CORDIC), .beg_add_subt(beg_add_subt),
    .ack_add_subt(ack_add_subt), .sel_mux_1(sel_mux_1), .sel_mux_2(sel_mux_2),
    .sel_mux_3(sel_mux_3), .mode(mode),
    .enab_cont_iter(enab_cont_iter), .load_cont_iter(load_cont_iter),
    .enab_cont_var(enab_cont_var), .load_cont_var(load_cont_var),
    .enab_RB1(enab_RB1), .enab_RB2(enab_RB2),
    .enab_d_ff_Xn(enab_d_ff_Xn), .enab_d_ff_Yn(enab_d_ff_Yn), .enab_d_ff_Zn(enab_d_ff_Zn),
    .enab_dff5(enab_dff5), .enab_d_ff_out(enab_d_ff_out),
    .enab_dff_shifted_x(enab_dff_shifted_x), .enab_dff_shifted_y(enab_dff_shifted_y),
    .enab_dff_LUT(enab_dff_LUT), .enab_dff_sign(enab_dff_sign)
  );

  localparam logic [22:0] M_READY = 23'(1) << 22;
  localparam logic [22:0] M_BEGA  = 23'(1) << 21;
  localparam logic [22:0] M_ACKA  = 23'(1) << 20;
  localparam logic [22:0] M_SEL1  = 23'(1) << 19;
  localparam logic [22:0] M_SEL3  = 23'(1) << 16;
  localparam logic [22:0] M_EITER = 23'(1) << 14;
  localparam logic [22:0] M_LITER = 23'(1) << 13;
  localparam logic [22:0] M_EVAR  = 23'(1) << 12;
  localparam logic [22:0] M_LVAR  = 23'(1) << 11;
  localparam logic [22:0] M_RB1   = 23'(1) << 10;
  localparam logic [22:0] M_RB2   = 23'(1) << 9;
  localparam logic [22:0] M_XN    = 23'(1) << 8;
  localparam logic [22:0] M_YN    = 23'(1) << 7;
  localparam logic [22:0] M_ZN    = 23'(1) << 6;
  localparam logic [22:0] M_DFF5  = 23'(1) << 5;
  localparam logic [22:0] M_DOUT  = 23'(1) << 4;
  localparam logic [22:0] M_SHIFT = 23'h00000F;
  localparam logic [22:0] M_IDLE  = M_LITER | M_LVAR;

  logic [22:0] outs;
  assign outs = {ready_CORDIC, beg_add_subt, ack_add_subt, sel_mux_1, sel_mux_2,
                 sel_mux_3, mode, enab_cont_iter, load_cont_iter, enab_cont_var,
                 load_cont_var, enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn,
                 enab_d_ff_Zn, enab_dff5, enab_d_ff_out, enab_dff_shifted_x,
                 enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign};

  function automatic logic [22:0] sel2(input logic [1:0] v);
    return 23'(v) << 17;
  endfunction

  task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; beg_FSM_CORDIC = 1'b0; ACK_FSM_CORDIC = 1'b0; operation = 1'b0;
    shift_region_flag = 2'b00; cont_var = 2'b00; ready_add_subt = 1'b0;
    max_tick_iter = 1'b0; min_tick_iter = 1'b0; max_tick_var = 1'b0; min_tick_var = 1'b0;

    // Reset: everything low
    tick(); tick();
    check("reset_all_zero", outs, 23'h0);
    reset = 1'b1; #1;
    check("idle_after_reset", outs, M_IDLE);
    tick();
    check("idle_hold", outs, M_IDLE);

    // Start of first iteration
    min_tick_iter = 1'b1; beg_FSM_CORDIC = 1'b1; #1;
    check("idle_beg", outs, M_IDLE);
    tick(); beg_FSM_CORDIC = 1'b0; #1;
    check("load", outs, M_RB1 | M_LITER | M_LVAR);
    tick();
    check("mux_first", outs, M_RB2);
    tick();
    check("shift_first", outs, M_SHIFT);
    tick(); cont_var = 2'b01; #1;
    check("add_y", outs, M_BEGA | sel2(2'b01));

    // Adder stall then completion on Y
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wait_stall", outs, sel2(2'b01));
    end
    ready_add_subt = 1'b1; #1;
    check("wait_done_y", outs, M_ACKA | M_EVAR | M_YN | sel2(2'b01));
    tick(); ready_add_subt = 1'b0; cont_var = 2'b10; #1;
    check("add_z", outs, M_BEGA | sel2(2'b10));
    tick(); ready_add_subt = 1'b1; max_tick_var = 1'b1; #1;
    check("wait_done_z_last", outs, M_ACKA | M_EVAR | M_ZN | sel2(2'b10));

    // Loop back for another iteration
    tick(); ready_add_subt = 1'b0; max_tick_var = 1'b0; min_tick_iter = 1'b0; #1;
    check("iter_loop", outs, M_EITER | M_LVAR);
    tick();
    check("mux_fb", outs, M_RB2 | M_SEL1);
    tick();
    check("shift_fb", outs, M_SHIFT | M_SEL1);
    tick(); cont_var = 2'b11; #1;
    check("add_11", outs, M_BEGA | sel2(2'b11));
    tick(); ready_add_subt = 1'b1; max_tick_var = 1'b1; max_tick_iter = 1'b1; #1;
    check("wait_done_11", outs, M_ACKA | M_EVAR | sel2(2'b11));
    tick(); ready_add_subt = 1'b0; max_tick_var = 1'b0; #1;
    check("iter_last", outs, 23'h0);

    // Output selection in OUT1
    tick(); operation = 1'b1; shift_region_flag = 2'b00; #1;
    check("out1_op1_f00", outs, M_DFF5 | M_SEL3);
    operation = 1'b1; shift_region_flag = 2'b01; #1;
    check("out1_op1_f01", outs, M_DFF5);
    operation = 1'b0; shift_region_flag = 2'b10; #1;
    check("out1_op0_f10", outs, M_DFF5 | M_SEL3);
    operation = 1'b0; shift_region_flag = 2'b11; #1;
    check("out1_op0_f11", outs, M_DFF5);
    tick(); operation = 1'b1; shift_region_flag = 2'b00; #1;
    check("out2", outs, M_DOUT | M_SEL3);

    // Result held until acknowledged
    tick();
    check("ready", outs, M_READY);
    tick();
    check("ready_hold", outs, M_READY);
    ACK_FSM_CORDIC = 1'b1; beg_FSM_CORDIC = 1'b1; #1;
    check("ready_ack", outs, M_READY);
    tick(); ACK_FSM_CORDIC = 1'b0; beg_FSM_CORDIC = 1'b0; #1;
`ifdef CORDIC_FSM_AUTO_RESTART_EN
    check("after_ack_restart", outs, M_RB1 | M_LITER | M_LVAR);
`else
    check("after_ack_idle", outs, M_IDLE);
    tick();
    check("idle_no_restart", outs, M_IDLE);
`endif

    // Re-run to WAIT, then assert reset mid-operation
    reset = 1'b0; #1;
    check("reset_again", outs, 23'h0);
    tick(); reset = 1'b1; min_tick_iter = 1'b1; max_tick_iter = 1'b0;
    cont_var = 2'b00; beg_FSM_CORDIC = 1'b1; #1;
    check("idle_restart", outs, M_IDLE);
    tick(); beg_FSM_CORDIC = 1'b0;
    tick(); tick(); tick();
    check("add_x", outs, M_BEGA);
    tick();
    check("wait_x", outs, 23'h0);
    ready_add_subt = 1'b1; #1;
    check("wait_done_x", outs, M_ACKA | M_EVAR | M_XN);
    reset = 1'b0; #1;
    check("reset_in_wait", outs, 23'h0);
    tick();
    check("reset_held", outs, 23'h0);
    ready_add_subt = 1'b0; reset = 1'b1; #1;
    check("idle_after_mid_reset", outs, M_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cordic_fsm_ctrl.md
Name: cordic_fsm_ctrl

Overview:
Control state machine for the iterative CORDIC sine/cosine datapath. It sequences input registering, per-iteration multiplexing, shift/LUT/sign capture, and X/Y/Z updates through a shared handshaked adder/subtractor. It also performs final output selection and the result handshake with the consumer. It drives only enables, selects and handshakes; all arithmetic lives in the datapath.

Parameters:
None. Widths are fixed: 2-bit variable index and 2-bit region flag.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
beg_FSM_CORDIC  in  1  start request, sampled in IDLE only
ACK_FSM_CORDIC  in  1  consumer has taken the result
operation  in  1  0 = cosine, 1 = sine
shift_region_flag  in  2  angle region: 00/11 direct; 01/10 swap X/Y roles
cont_var  in  2  variable counter value: 00 = X, 01 = Y, 10 = Z
ready_add_subt  in  1  adder result valid
max_tick_iter, min_tick_iter  in  1 each  iteration counter at max / at min
max_tick_var, min_tick_var  in  1 each  variable counter at max / at min
ready_CORDIC  out  1  result valid, held until ACK
beg_add_subt, ack_add_subt  out  1 each  adder start / adder result consumed
sel_mux_1  out  1  0 = initial inputs (first iteration), 1 = fed-back Xn/Yn/Zn
sel_mux_2  out  2  adder operand select, equals cont_var
sel_mux_3  out  1  output select: 0 = X, 1 = Y
mode  out  1  0 = rotation (tied 0)
enab_cont_iter, load_cont_iter  out  1 each  iteration counter increment / load
enab_cont_var, load_cont_var  out  1 each  variable counter increment / load
enab_RB1, enab_RB2  out  1 each  input register bank / post-mux register bank
enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn  out  1 each  iteration result registers
enab_dff5, enab_d_ff_out  out  1 each  pre-sign output register / final output register
enab_dff_shifted_x, enab_dff_shifted_y  out  1 each  shifted X/Y registers
enab_dff_LUT, enab_dff_sign  out  1 each  arctan LUT register / sign register

Behaviour:
- States (one-hot or binary, registered): IDLE, LOAD, MUX, SHIFT, ADD, WAIT, ITER, OUT1, OUT2, READY.
- reset low: state goes to IDLE immediately (also mid-operation). Every output is 0 during reset. After reset, IDLE decode applies.
- Outputs are combinational decode of state. Unlisted outputs are 0. mode is always 0.
- IDLE: load_cont_iter = load_cont_var = 1. If beg_FSM_CORDIC = 1, go to LOAD.
- LOAD: enab_RB1 = 1, load_cont_iter = load_cont_var = 1. Go to MUX.
- MUX: enab_RB2 = 1, sel_mux_1 = ~min_tick_iter. Go to SHIFT.
- SHIFT: enab_dff_shifted_x = enab_dff_shifted_y = enab_dff_LUT = enab_dff_sign = 1, sel_mux_1 = ~min_tick_iter. Go to ADD.
- ADD: beg_add_subt = 1 (exactly one cycle per variable), sel_mux_2 = cont_var. Go to WAIT.
- WAIT: sel_mux_2 = cont_var.
  - While ready_add_subt = 0, stay in WAIT.
  - When ready_add_subt = 1, in the same cycle: ack_add_subt = 1 and enab_cont_var = 1.
  - Also assert enab_d_ff_Xn, enab_d_ff_Yn or enab_d_ff_Zn for cont_var 00, 01 or 10. For cont_var 11, assert none but still ack.
  - Then, if max_tick_var = 1, go to ITER; otherwise go to ADD.
- ITER: if max_tick_iter = 1, go to OUT1. Otherwise enab_cont_iter = 1 and load_cont_var = 1, then go to MUX.
- OUT1: enab_dff5 = 1. sel_mux_3 = operation XOR (shift_region_flag == 01 or == 10). Go to OUT2.
- OUT2: enab_d_ff_out = 1, same sel_mux_3 decode. Go to READY.
- READY: ready_CORDIC = 1. If ACK_FSM_CORDIC = 1, go to IDLE; otherwise hold.
- beg_FSM_CORDIC is ignored outside IDLE. ready_add_subt is ignored outside WAIT. ACK_FSM_CORDIC is ignored outside READY.
- If ready_add_subt and max_tick_var are both 1 in WAIT, the last variable is committed before leaving to ITER.
- Latency: beg_FSM_CORDIC sampled high in IDLE → beg_add_subt high 4 cycles later (LOAD, MUX, SHIFT, ADD).
- Unreachable state encodings go to IDLE.

Optional Feature:
CORDIC_FSM_AUTO_RESTART_EN.
- Defined: in READY, if ACK_FSM_CORDIC = 1 and beg_FSM_CORDIC = 1 in the same cycle, go directly to LOAD, skipping IDLE.
- Undefined: READY always returns to IDLE on ACK, and a new start needs beg_FSM_CORDIC high while in IDLE.

Test Plan:
- Reset: hold reset = 0 → all outputs 0. Release, beg = 0 → load_cont_iter = load_cont_var = 1, other outputs 0.
- Start: beg pulse 1 cycle with min_tick_iter = 1 → enab_RB1, then enab_RB2 with sel_mux_1 = 0, then shift/LUT/sign enables, then beg_add_subt for exactly 1 cycle. ready_CORDIC stays 0.
- Adder handshake: in WAIT with cont_var = 01, hold ready_add_subt = 0 for 5 cycles → no ack. Raise ready → ack_add_subt, enab_d_ff_Yn and enab_cont_var each high for 1 cycle, then beg_add_subt again (max_tick_var = 0).
- Iteration loop: max_tick_var = 1, max_tick_iter = 0, min_tick_iter = 0 → enab_cont_iter + load_cont_var, then MUX with sel_mux_1 = 1. With max_tick_iter = 1 instead: enab_dff5, then enab_d_ff_out, then ready_CORDIC.
- Output select: check sel_mux_3 in OUT1 for four cases. operation = 1, flag = 00 → 1. operation = 1, flag = 01 → 0. operation = 0, flag = 10 → 1. operation = 0, flag = 11 → 0.
- Completion/reset: ACK held 0 → ready_CORDIC stays 1. ACK = 1 → IDLE next cycle. Separately, reset asserted while in WAIT → IDLE and all outputs 0 immediately.
